// File: rtl/color_judge_pkg.sv
// Shared constants, FSM state type and RGB565 -> RGB888 expansion for the colour class judge.
package color_judge_pkg;

  localparam int CH_W  = 8;
  localparam int R_OFS = 16;
  localparam int G_OFS = 8;
  localparam int B_OFS = 0;

  localparam int R565_HI = 15;
  localparam int R565_LO = 11;
  localparam int G565_HI = 10;
  localparam int G565_LO = 5;
  localparam int B565_HI = 4;
  localparam int B565_LO = 0;

  typedef enum logic [1:0] {IDLE, COUNT, DRAIN, DECIDE} state_e;

  // MSBs are replicated into the new LSBs so full-scale 5/6-bit values map to 255.
  function automatic logic [3*CH_W-1:0] rgb565_to_888(input logic [15:0] p);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = p[R565_HI:R565_LO];
    g = p[G565_HI:G565_LO];
    b = p[B565_HI:B565_LO];
    return {r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

endpackage

// File: rtl/color_class_judge_if.sv
// Pixel stream in, per-frame decision out, for the colour class judge.
interface color_class_judge_if #(
  parameter int N_CLASS = 2,
  parameter int CLS_W   = 3
);
  // pix_valid qualifies pix_rgb for one cycle; there is no backpressure, every
  // qualified pixel is taken while a frame is open. frame_start/frame_end and
  // result_valid are single-cycle pulses; result_* hold until the next result_valid.
  logic               pix_valid;
  logic [15:0]        pix_rgb;
  logic               frame_start;
  logic               frame_end;
  logic               result_valid;
  logic [N_CLASS-1:0] result_onehot;
  logic [CLS_W-1:0]   result_idx;
  logic               result_none;

  modport master (
    output pix_valid, pix_rgb, frame_start, frame_end,
    input  result_valid, result_onehot, result_idx, result_none
  );

  modport slave (
    input  pix_valid, pix_rgb, frame_start, frame_end,
    output result_valid, result_onehot, result_idx, result_none
  );
endinterface

// File: rtl/color_range_cmp.sv
// One expanded pixel against one class's inclusive RGB box; lo > hi on a channel never matches.
module color_range_cmp
  import color_judge_pkg::*;
(
  input  logic [3*CH_W-1:0] rgb,
  input  logic [3*CH_W-1:0] lo,
  input  logic [3*CH_W-1:0] hi,
  output logic              hit
);

  function automatic logic in_box(input logic [CH_W-1:0] v,
                                  input logic [CH_W-1:0] l,
                                  input logic [CH_W-1:0] h);
    return (v >= l) && (v <= h);
  endfunction

  assign hit = in_box(rgb[R_OFS +: CH_W], lo[R_OFS +: CH_W], hi[R_OFS +: CH_W]) &&
               in_box(rgb[G_OFS +: CH_W], lo[G_OFS +: CH_W], hi[G_OFS +: CH_W]) &&
               in_box(rgb[B_OFS +: CH_W], lo[B_OFS +: CH_W], hi[B_OFS +: CH_W]);

endmodule

// File: rtl/color_class_judge.sv
// Per-frame colour classifier: counts per-class box matches and reports the lowest-index qualifying class.
// Define COLOR_JUDGE_HYST_EN to publish a decision only after HYST_FRAMES identical raw decisions.
module color_class_judge
  import color_judge_pkg::*;
#(
  parameter int N_CLASS     = 2,
  parameter int CNT_W       = 20,
  parameter int CLS_W       = 3,
  parameter int HYST_FRAMES = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  color_class_judge_if.slave        bus,
  input  logic [3*CH_W*N_CLASS-1:0] cfg_lo,
  input  logic [3*CH_W*N_CLASS-1:0] cfg_hi,
  input  logic [CNT_W-1:0]          cfg_min_cnt,
  output logic [N_CLASS-1:0]        class_hit,
  output logic                      busy,
  output state_e                    dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (N_CLASS < 1 || N_CLASS > 8 || (1 << CLS_W) < N_CLASS || HYST_FRAMES < 1) begin : g_bad_param
    $error("color_class_judge: inconsistent N_CLASS/CLS_W/HYST_FRAMES");
  end

  state_e                    state_q, state_d;
  logic                      drain_q;
  logic                      start_acc;
  logic                      pix_acc;
  logic                      commit;
  logic [3*CH_W*N_CLASS-1:0] sh_lo, sh_hi, use_lo, use_hi;
  logic [CNT_W-1:0]          sh_min;
  logic [CNT_W-1:0]          cnt_q [N_CLASS];
  logic [3*CH_W-1:0]         pix888;
  logic [N_CLASS-1:0]        hit_d;
  logic                      raw_none;
  logic [CLS_W-1:0]          raw_idx;
  logic [N_CLASS-1:0]        raw_onehot;
  logic                      res_valid_q, res_none_q;
  logic [CLS_W-1:0]          res_idx_q;
  logic [N_CLASS-1:0]        res_onehot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // frame_start outside IDLE/COUNT is ignored: the previous frame's decision is still in flight.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          start_acc = 1'b1;
          state_d   = COUNT;
        end
      end
      COUNT: begin
        if (bus.frame_start)    start_acc = 1'b1;
        else if (bus.frame_end) state_d   = DRAIN;
      end
      DRAIN:   if (drain_q) state_d = DECIDE;
      DECIDE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == COUNT);
  assign dbg_state = state_q;

  // Two DRAIN cycles let the last pixel pass the hit and counter stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drain_q <= 1'b0;
    else        drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_lo  <= '0;
      sh_hi  <= '0;
      sh_min <= '0;
    end else if (start_acc) begin
      sh_lo  <= cfg_lo;
      sh_hi  <= cfg_hi;
      sh_min <= cfg_min_cnt;
    end
  end

  // A pixel arriving with frame_start belongs to the new frame, so it sees the new bounds.
  assign use_lo  = start_acc ? cfg_lo : sh_lo;
  assign use_hi  = start_acc ? cfg_hi : sh_hi;
  assign pix888  = rgb565_to_888(bus.pix_rgb);
  assign pix_acc = bus.pix_valid && (start_acc || (state_q == COUNT));

  for (genvar k = 0; k < N_CLASS; k++) begin : g_cmp
    color_range_cmp u_cmp (
      .rgb (pix888),
      .lo  (use_lo[k*3*CH_W +: 3*CH_W]),
      .hi  (use_hi[k*3*CH_W +: 3*CH_W]),
      .hit (hit_d[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) class_hit <= '0;
    else        class_hit <= pix_acc ? hit_d : '0;
  end

  // Clearing on frame_start also drops an old-frame hit still in the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CLASS; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_CLASS; k++) begin
        if (start_acc)                               cnt_q[k] <= '0;
        else if (class_hit[k] && cnt_q[k] != CNT_MAX) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    raw_none   = 1'b1;
    raw_idx    = '0;
    raw_onehot = '0;
    for (int k = N_CLASS - 1; k >= 0; k--) begin
      if (cnt_q[k] >= sh_min) begin
        raw_none   = 1'b0;
        raw_idx    = CLS_W'(k);
        raw_onehot = '0;
        raw_onehot[k] = 1'b1;
      end
    end
  end

`ifdef COLOR_JUDGE_HYST_EN
  localparam int AG_W = $clog2(HYST_FRAMES + 1);

  logic [AG_W-1:0]  agree_q, agree_d;
  logic             prev_none_q;
  logic [CLS_W-1:0] prev_idx_q;
  logic             same_raw;

  // agree_q == 0 means no decision seen since reset.
  assign same_raw = (agree_q != '0) && (raw_none == prev_none_q) && (raw_idx == prev_idx_q);

  always_comb begin
    agree_d = AG_W'(1);
    if (same_raw) agree_d = (agree_q == AG_W'(HYST_FRAMES)) ? agree_q : agree_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      agree_q     <= '0;
      prev_none_q <= 1'b1;
      prev_idx_q  <= '0;
    end else if (state_q == DECIDE) begin
      agree_q     <= agree_d;
      prev_none_q <= raw_none;
      prev_idx_q  <= raw_idx;
    end
  end

  assign commit = (state_q == DECIDE) && (agree_d == AG_W'(HYST_FRAMES)) &&
                  ({raw_none, raw_idx} != {res_none_q, res_idx_q});
`else
  assign commit = (state_q == DECIDE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q  <= 1'b0;
      res_none_q   <= 1'b1;
      res_idx_q    <= '0;
      res_onehot_q <= '0;
    end else begin
      res_valid_q <= 1'b0;
      if (commit) begin
        res_valid_q  <= 1'b1;
        res_none_q   <= raw_none;
        res_idx_q    <= raw_idx;
        res_onehot_q <= raw_onehot;
      end
    end
  end

  assign bus.result_valid  = res_valid_q;
  assign bus.result_none   = res_none_q;
  assign bus.result_idx    = res_idx_q;
  assign bus.result_onehot = res_onehot_q;

endmodule
